// File: rtl/param_bus_datapath.sv
// Single-bus CPU datapath. Holds the register file, PC/IR/Y/Z/HI/LO/MAR/MDR and a sequenced ALU.
// The ALU runs 1-cycle ops and iterative signed MUL/DIV under a start/busy/done handshake.
module param_bus_datapath #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [NREGS-1:0] reg_in,
  input  logic [NREGS-1:0] reg_out,
  input  logic             pc_in,
  input  logic             pc_out,
  input  logic             inc_pc,
  input  logic             ir_in,
  input  logic             y_in,
  input  logic             mar_in,
  input  logic             hi_in,
  input  logic             lo_in,
  input  logic             hi_out,
  input  logic             lo_out,
  input  logic             zhi_out,
  input  logic             zlo_out,
  input  logic             mdr_out,
  input  logic             inport_out,
  input  logic             c_out,
  input  logic             mdr_in,
  input  logic             read,
  input  logic [WIDTH-1:0] mdatain,
  input  logic [WIDTH-1:0] inport,
  input  logic [WIDTH-1:0] c_sext,
  input  logic [3:0]       alu_op,
  input  logic             alu_start,
  output logic             alu_busy,
  output logic             alu_done,
  output logic             div_zero,
  output logic             bus_conflict,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] mar_q,
  output logic [WIDTH-1:0] ir_q,
  output logic [1:0]       alu_state
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int NSRC = NREGS + 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_NEG  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SHRA = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } alu_state_t;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] pc, y, hi, lo, mdr, z_hi, z_lo;

  // ---------------- shared bus ----------------
  logic [NSRC-1:0]  drv_sel;
  logic [WIDTH-1:0] drv_val [NSRC];
  logic [WIDTH-1:0] bus_or;

  assign drv_sel = {c_out, inport_out, mdr_out, zlo_out, zhi_out, lo_out, hi_out, pc_out, reg_out};

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      drv_val[i] = (R0_ZERO && i == 0) ? '0 : regs[i];
    end
    drv_val[NREGS]     = pc;
    drv_val[NREGS + 1] = hi;
    drv_val[NREGS + 2] = lo;
    drv_val[NREGS + 3] = z_hi;
    drv_val[NREGS + 4] = z_lo;
    drv_val[NREGS + 5] = mdr;
    drv_val[NREGS + 6] = inport;
    drv_val[NREGS + 7] = c_sext;
  end

  always_comb begin
    bus_or = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (drv_sel[i]) bus_or = bus_or | drv_val[i];
    end
  end

  // Clearing the lowest set bit leaves something only if two or more selects are active.
  assign bus_conflict = |(drv_sel & (drv_sel - NSRC'(1)));
  assign bus          = bus_conflict ? '0 : bus_or;

  // ---------------- bus loads ----------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pc    <= '0;
      ir_q  <= '0;
      y     <= '0;
      mar_q <= '0;
      hi    <= '0;
      lo    <= '0;
      mdr   <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (reg_in[i] && !(R0_ZERO && i == 0)) regs[i] <= bus;
      end
      if (pc_in)       pc <= bus;
      else if (inc_pc) pc <= pc + WIDTH'(1);
      if (ir_in)  ir_q  <= bus;
      if (y_in)   y     <= bus;
      if (mar_in) mar_q <= bus;
      if (hi_in)  hi    <= bus;
      if (lo_in)  lo    <= bus;
      if (mdr_in) mdr   <= read ? mdatain : bus;
    end
  end

  // ---------------- single-cycle ALU ----------------
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] rot_l, rot_r;
  logic [WIDTH-1:0]   simple_res;

  assign shamt = bus[SHW-1:0];

  // NOT and NEG are unary on B (the bus), so they need no Y load.
  always_comb begin
    rot_l      = {y, y} << shamt;
    rot_r      = {y, y} >> shamt;
    simple_res = '0;
    case (alu_op)
      OP_ADD:  simple_res = y + bus;
      OP_SUB:  simple_res = y - bus;
      OP_AND:  simple_res = y & bus;
      OP_OR:   simple_res = y | bus;
      OP_NOT:  simple_res = ~bus;
      OP_NEG:  simple_res = '0 - bus;
      OP_SHL:  simple_res = y << shamt;
      OP_SHR:  simple_res = y >> shamt;
      OP_SHRA: simple_res = WIDTH'($signed(y) >>> shamt);
      OP_ROL:  simple_res = rot_l[2*WIDTH-1:WIDTH];
      OP_ROR:  simple_res = rot_r[WIDTH-1:0];
      default: simple_res = '0;
    endcase
  end

  // ---------------- iterative MUL/DIV ----------------
  alu_state_t       state;
  logic             op_div, neg_res, neg_rem;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mag, p_hi, p_lo;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic             div_ge;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0] fix_quo, fix_rem;

  assign a_neg = y[WIDTH-1];
  assign b_neg = bus[WIDTH-1];
  assign a_mag = a_neg ? '0 - y : y;
  assign b_mag = b_neg ? '0 - bus : bus;

  // MUL: {p_hi,p_lo} is the shift-add product register, multiplier starting in p_lo.
  // DIV: p_hi is the partial remainder, p_lo shifts the dividend out and the quotient in.
  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mag} : '0);
  assign div_shift = {p_hi, p_lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mag};
  assign div_ge    = ~div_trial[WIDTH];

  assign fix_prod = neg_res ? '0 - {p_hi, p_lo} : {p_hi, p_lo};
  assign fix_quo  = neg_res ? '0 - p_lo : p_lo;
  assign fix_rem  = neg_rem ? '0 - p_hi : p_hi;

  assign alu_state = state;

  // Handshake: alu_start is sampled only in IDLE (ignored while alu_busy); operands are captured
  // at that edge. alu_done is a one-cycle pulse in the cycle after Z is written, with busy already low.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= ST_IDLE;
      alu_busy <= 1'b0;
      alu_done <= 1'b0;
      div_zero <= 1'b0;
      z_hi     <= '0;
      z_lo     <= '0;
      op_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
      mag      <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
    end else begin
      alu_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (alu_start) begin
            div_zero <= 1'b0;
            if (alu_op == OP_MUL) begin
              op_div   <= 1'b0;
              p_hi     <= '0;
              p_lo     <= b_mag;
              mag      <= a_mag;
              neg_res  <= a_neg ^ b_neg;
              cnt      <= '0;
              alu_busy <= 1'b1;
              state    <= ST_ITER;
            end else if (alu_op == OP_DIV) begin
              if (bus == '0) begin
                z_lo     <= '0;
                z_hi     <= y;
                div_zero <= 1'b1;
                alu_done <= 1'b1;
              end else begin
                op_div   <= 1'b1;
                p_hi     <= '0;
                p_lo     <= a_mag;
                mag      <= b_mag;
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                cnt      <= '0;
                alu_busy <= 1'b1;
                state    <= ST_ITER;
              end
            end else begin
              if (alu_op <= OP_ROR) begin
                z_lo <= simple_res;
                z_hi <= '0;
              end
              alu_done <= 1'b1;
            end
          end
        end
        ST_ITER: begin
          if (op_div) begin
            p_hi <= div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            p_lo <= {p_lo[WIDTH-2:0], div_ge};
          end else begin
            {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
          end
          cnt <= cnt + SHW'(1);
          if (&cnt) state <= ST_FIX;
        end
        ST_FIX: begin
          if (op_div) begin
            z_lo <= fix_quo;
            z_hi <= fix_rem;
          end else begin
            {z_hi, z_lo} <= fix_prod;
          end
          alu_done <= 1'b1;
          alu_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          alu_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_bus_datapath.sv
// Bench for param_bus_datapath: directed bus/load checks plus random ALU ops
// compared against an arithmetic reference model.
module tb_param_bus_datapath;

  localparam int W = 32;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] reg_in, reg_out;
  logic         pc_in, pc_out, inc_pc, ir_in, y_in, mar_in, hi_in, lo_in;
  logic         hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out, c_out;
  logic         mdr_in, read;
  logic [W-1:0] mdatain, inport, c_sext;
  logic [3:0]   alu_op;
  logic         alu_start;
  logic         alu_busy, alu_done, div_zero, bus_conflict;
  logic [W-1:0] bus, mar_q, ir_q;
  logic [1:0]   alu_state;

  param_bus_datapath #(.WIDTH(W), .NREGS(N), .R0_ZERO(1'b1)) dut (
    .clk(clk), .clr(clr), .reg_in(reg_in), .reg_out(reg_out),
    .pc_in(pc_in), .pc_out(pc_out), .inc_pc(inc_pc), .ir_in(ir_in), .y_in(y_in),
    .mar_in(mar_in), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
    .zhi_out(zhi_out), .zlo_out(zlo_out), .mdr_out(mdr_out), .inport_out(inport_out),
    .c_out(c_out), .mdr_in(mdr_in), .read(read), .mdatain(mdatain), .inport(inport),
    .c_sext(c_sext), .alu_op(alu_op), .alu_start(alu_start), .alu_busy(alu_busy),
    .alu_done(alu_done), .div_zero(div_zero), .bus_conflict(bus_conflict), .bus(bus),
    .mar_q(mar_q), .ir_q(ir_q), .alu_state(alu_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_zhi, m_zlo, prev_zlo;
  bit           m_dz;
  logic [W-1:0] m_regs [N];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    reg_in = '0; reg_out = '0;
    {pc_in, pc_out, inc_pc, ir_in, y_in, mar_in, hi_in, lo_in} = '0;
    {hi_out, lo_out, zhi_out, zlo_out, mdr_out, inport_out, c_out} = '0;
    {mdr_in, read, alu_start} = '0;
    mdatain = '0; inport = '0; c_sext = '0; alu_op = '0;
  endtask

  task automatic load_reg(input int i, input logic [W-1:0] v);
    c_sext = v; c_out = 1'b1; reg_in[i] = 1'b1;
    tick();
    c_out = 1'b0; reg_in = '0;
  endtask

  task automatic read_reg(input int i, output logic [W-1:0] v);
    reg_out[i] = 1'b1;
    #1 v = bus;
    reg_out = '0;
  endtask

  task automatic load_y(input logic [W-1:0] v);
    c_sext = v; c_out = 1'b1; y_in = 1'b1;
    tick();
    c_out = 1'b0; y_in = 1'b0;
  endtask

  // Reference ALU: plain signed/unsigned arithmetic on wide integers.
  task automatic model_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa, sb, p;
    int           amt;
    logic [W-1:0] r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    amt  = int'(b % W);
    m_dz = 1'b0;
    r    = a;
    case (op)
      4'd0:  begin m_zlo = a + b;  m_zhi = '0; end
      4'd1:  begin m_zlo = a - b;  m_zhi = '0; end
      4'd2:  begin m_zlo = a & b;  m_zhi = '0; end
      4'd3:  begin m_zlo = a | b;  m_zhi = '0; end
      4'd4:  begin m_zlo = ~b;     m_zhi = '0; end
      4'd5:  begin m_zlo = W'(-sb); m_zhi = '0; end
      4'd6:  begin m_zlo = a << amt; m_zhi = '0; end
      4'd7:  begin m_zlo = a >> amt; m_zhi = '0; end
      4'd8:  begin m_zlo = W'(sa >>> amt); m_zhi = '0; end
      4'd9:  begin
        for (int k = 0; k < amt; k++) r = {r[W-2:0], r[W-1]};
        m_zlo = r; m_zhi = '0;
      end
      4'd10: begin
        for (int k = 0; k < amt; k++) r = {r[0], r[W-1:1]};
        m_zlo = r; m_zhi = '0;
      end
      4'd11: begin
        p = sa * sb;
        m_zlo = p[W-1:0];
        m_zhi = p[2*W-1:W];
      end
      4'd12: begin
        if (b == '0) begin
          m_zlo = '0; m_zhi = a; m_dz = 1'b1;
        end else begin
          m_zlo = W'(sa / sb);
          m_zhi = W'(sa % sb);
        end
      end
      default: ;
    endcase
  endtask

  // Starts an op and counts cycles after the start edge (cycle 1 follows it) until done.
  task automatic alu_run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke, output int done_cyc, output int busy_cyc);
    load_y(a);
    alu_op = op; c_sext = b; c_out = 1'b1; alu_start = 1'b1;
    tick();
    alu_start = 1'b0; c_out = 1'b0;
    done_cyc = 0; busy_cyc = 0;
    for (int cyc = 1; cyc <= 100 && done_cyc == 0; cyc++) begin
      if (alu_busy) busy_cyc++;
      if (alu_done) begin
        done_cyc = cyc;
      end else begin
        if (poke && cyc == 3) begin
          zlo_out = 1'b1;
          #1 check_eq("z_read_while_busy", bus, prev_zlo);
          zlo_out = 1'b0;
        end
        if (poke && cyc == 5) begin
          c_sext = 32'h0000_1234; c_out = 1'b1; y_in = 1'b1; alu_start = 1'b1; alu_op = 4'd0;
        end
        tick();
        c_out = 1'b0; y_in = 1'b0; alu_start = 1'b0;
      end
    end
    alu_op = '0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke);
    int done_cyc, busy_cyc, exp_lat, exp_busy;
    bit iter;
    iter     = (op == 4'd11) || (op == 4'd12 && b != '0);
    exp_lat  = iter ? W + 2 : 1;
    exp_busy = iter ? W + 1 : 0;
    prev_zlo = m_zlo;
    model_alu(op, a, b);
    exp_q.push_back(m_zlo);
    exp_q.push_back(m_zhi);
    alu_run(op, a, b, poke, done_cyc, busy_cyc);
    check_eq($sformatf("done_latency op%0d", op), done_cyc, exp_lat);
    check_eq($sformatf("busy_cycles op%0d", op), busy_cyc, exp_busy);
    check_eq($sformatf("div_zero op%0d", op), div_zero, m_dz);
    zlo_out = 1'b1;
    #1 check_eq($sformatf("z_lo op%0d a=%0h b=%0h", op, a, b), bus, exp_q.pop_front());
    zlo_out = 1'b0; zhi_out = 1'b1;
    #1 check_eq($sformatf("z_hi op%0d a=%0h b=%0h", op, a, b), bus, exp_q.pop_front());
    zhi_out = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] v, w;
    logic [3:0]   op;
    int           i, j;
    bit           seen;

    idle_ctl();
    clr = 1'b0;
    m_zhi = '0; m_zlo = '0; m_dz = 1'b0;
    for (int k = 0; k < N; k++) m_regs[k] = '0;
    repeat (3) @(posedge clk);
    #3;
    check_eq("rst_busy", alu_busy, 1'b0);
    check_eq("rst_done", alu_done, 1'b0);
    check_eq("rst_div_zero", div_zero, 1'b0);
    check_eq("rst_state", alu_state, 2'd0);
    check_eq("rst_mar", mar_q, '0);
    check_eq("rst_ir", ir_q, '0);
    clr = 1'b1;
    tick();
    pc_out = 1'b1;
    #1 check_eq("rst_pc", bus, '0);
    pc_out = 1'b0;
    read_reg(5, v);
    check_eq("rst_r5", v, '0);

    // Bus drive and contention
    load_reg(3, 32'h0000_00A5);
    read_reg(3, v);
    check_eq("bus_r3", v, 32'h0000_00A5);
    check_eq("bus_no_conflict", bus_conflict, 1'b0);
    reg_out[3] = 1'b1; pc_out = 1'b1;
    #1 check_eq("conflict_bus", bus, '0);
    check_eq("conflict_flag", bus_conflict, 1'b1);
    reg_out = '0; pc_out = 1'b0;
    inport = 32'hCAFE_0001; inport_out = 1'b1; c_out = 1'b1; c_sext = 32'h1;
    #1 check_eq("conflict2_flag", bus_conflict, 1'b1);
    c_out = 1'b0;
    #1 check_eq("inport_bus", bus, 32'hCAFE_0001);
    check_eq("idle_no_conflict", bus_conflict, 1'b0);
    inport_out = 1'b0;
    #1 check_eq("no_sel_bus", bus, '0);

    // R0 reads as zero
    load_reg(0, 32'h77);
    read_reg(0, v);
    check_eq("r0_zero", v, '0);

    // Broadcast load of MAR/IR/HI, then LO
    c_sext = 32'hDEAD_BEEF; c_out = 1'b1; mar_in = 1'b1; ir_in = 1'b1; hi_in = 1'b1;
    tick();
    c_sext = 32'h0BAD_F00D; mar_in = 1'b0; ir_in = 1'b0; hi_in = 1'b0; lo_in = 1'b1;
    tick();
    c_out = 1'b0; lo_in = 1'b0;
    check_eq("mar_load", mar_q, 32'hDEAD_BEEF);
    check_eq("ir_load", ir_q, 32'hDEAD_BEEF);
    hi_out = 1'b1;
    #1 check_eq("hi_load", bus, 32'hDEAD_BEEF);
    hi_out = 1'b0; lo_out = 1'b1;
    #1 check_eq("lo_load", bus, 32'h0BAD_F00D);
    lo_out = 1'b0;

    // PC wrap and pc_in priority
    c_sext = 32'hFFFF_FFFF; c_out = 1'b1; pc_in = 1'b1;
    tick();
    c_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b1;
    tick();
    inc_pc = 1'b0; pc_out = 1'b1;
    #1 check_eq("pc_wrap", bus, '0);
    pc_out = 1'b0;
    c_sext = 32'h40; c_out = 1'b1; pc_in = 1'b1; inc_pc = 1'b1;
    tick();
    c_out = 1'b0; pc_in = 1'b0;
    tick();
    inc_pc = 1'b0; pc_out = 1'b1;
    #1 check_eq("pc_load_then_inc", bus, 32'h41);
    pc_out = 1'b0;

    // MDR source select
    mdatain = 32'h1234; read = 1'b1; mdr_in = 1'b1; c_sext = 32'h55; c_out = 1'b1;
    tick();
    read = 1'b0;
    tick();
    mdr_in = 1'b0; c_out = 1'b0; mdr_out = 1'b1;
    #1 check_eq("mdr_from_bus", bus, 32'h55);
    mdr_out = 1'b0;
    read = 1'b1; mdr_in = 1'b1;
    tick();
    read = 1'b0; mdr_in = 1'b0; mdr_out = 1'b1;
    #1 check_eq("mdr_from_mem", bus, 32'h1234);
    mdr_out = 1'b0;

    // Directed ALU cases
    do_op(4'd8,  32'hFFFF_FFF0, 32'd2, 1'b0);
    do_op(4'd9,  32'h8000_0001, 32'd1, 1'b0);
    do_op(4'd11, 32'hFFFF_FFF9, 32'd6, 1'b1);
    do_op(4'd12, 32'hFFFF_FFEF, 32'd5, 1'b0);
    do_op(4'd12, 32'd9, 32'd0, 1'b0);
    do_op(4'd0,  32'd1, 32'd2, 1'b0);
    do_op(4'd13, 32'd3, 32'd4, 1'b0);
    do_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(4'd11, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(4'd10, 32'h0000_0001, 32'd33, 1'b0);
    do_op(4'd5,  32'd0, 32'h8000_0000, 1'b0);

    // Random register traffic
    for (int k = 0; k < 12; k++) begin
      i = $urandom_range(0, N - 1);
      v = $urandom;
      load_reg(i, v);
      if (i != 0) m_regs[i] = v;
      j = $urandom_range(0, N - 1);
      read_reg(j, w);
      check_eq($sformatf("reg_read r%0d", j), w, m_regs[j]);
    end

    // Random ALU ops
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15));
      v  = $urandom;
      w  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      if (op == 4'd12 && $urandom_range(0, 3) == 0) w = '0;
      if ($urandom_range(0, 7) == 0) v = -v;
      do_op(op, v, w, 1'b0);
    end

    // Reset in the middle of a MUL: no resumption, no Z write afterwards
    load_y(32'hFFFF_FFF9);
    c_sext = 32'd6; c_out = 1'b1; alu_op = 4'd11; alu_start = 1'b1;
    tick();
    c_out = 1'b0; alu_start = 1'b0;
    repeat (10) tick();
    check_eq("mid_mul_busy", alu_busy, 1'b1);
    #2 clr = 1'b0;
    #1 check_eq("abort_busy", alu_busy, 1'b0);
    check_eq("abort_done", alu_done, 1'b0);
    check_eq("abort_state", alu_state, 2'd0);
    check_eq("abort_mar", mar_q, '0);
    zlo_out = 1'b1;
    #1 check_eq("abort_zlo", bus, '0);
    zlo_out = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    alu_op = '0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (alu_done || alu_busy) seen = 1'b1;
    end
    check_eq("abort_no_resume", seen, 1'b0);
    zlo_out = 1'b1;
    #1 check_eq("abort_zlo_after", bus, '0);
    zlo_out = 1'b0; zhi_out = 1'b1;
    #1 check_eq("abort_zhi_after", bus, '0);
    zhi_out = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
